// File: rtl/iq_stream_arbiter.sv
// Merges I and Q sample streams onto one tagged, framed AXI-Stream output.
// Define IQ_STRICT_ALT_EN for strict I/Q alternation instead of work-conserving round-robin.
module iq_stream_arbiter #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_axis_i_tdata,
  input  logic              s_axis_i_tvalid,
  output logic              s_axis_i_tready,
  input  logic [DATA_W-1:0] s_axis_q_tdata,
  input  logic              s_axis_q_tvalid,
  output logic              s_axis_q_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              running
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] frame_cnt, frame_cnt_nxt;

  logic [1:0]             in_vld, in_rdy, wr_en, rd_en, full, empty;
  logic [1:0][DATA_W-1:0] in_data, head;

  logic              gnt_vld, gnt_ch, load, last_word;
  logic [DATA_W-1:0] tdata_p1;
  logic              tuser_p1, tlast_p1, vld_p1;

  assign in_vld  = {s_axis_q_tvalid, s_axis_i_tvalid};
  assign in_data = {s_axis_q_tdata, s_axis_i_tdata};
  assign s_axis_i_tready = in_rdy[0];
  assign s_axis_q_tready = in_rdy[1];

  // Stage p0: per-channel input FIFOs (index 0 = I, 1 = Q)
  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;

    assign full[ch]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty[ch] = (wr_ptr == rd_ptr);
    assign in_rdy[ch] = !full[ch] && !rst;
    assign wr_en[ch]  = in_vld[ch] && in_rdy[ch];
    assign head[ch]   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en[ch]) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en[ch]) rd_ptr <= rd_ptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[ch]) mem[wr_ptr[AW-1:0]] <= in_data[ch];
    end
  end

`ifdef IQ_STRICT_ALT_EN
  always_comb begin
    gnt_ch  = frame_cnt[0];
    gnt_vld = !empty[frame_cnt[0]];
  end
`else
  logic last_q;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = 1'b0;
    if (!empty[!last_q]) begin
      gnt_vld = 1'b1;
      gnt_ch  = !last_q;
    end else if (!empty[last_q]) begin
      gnt_vld = 1'b1;
      gnt_ch  = last_q;
    end
  end

  // Pointer starts at Q so that I is served first after reset.
  always_ff @(posedge clk) begin
    if (rst)       last_q <= 1'b1;
    else if (load) last_q <= gnt_ch;
  end
`endif

  assign load      = (!vld_p1 || m_axis_tready) && (state != IDLE) && gnt_vld;
  assign rd_en[0]  = load && !gnt_ch;
  assign rd_en[1]  = load && gnt_ch;
  assign last_word = (frame_cnt == LAST_CNT);

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (load) frame_cnt_nxt = last_word ? '0 : frame_cnt + 1'b1;
  end

  // Stopping is decided on the post-load count so a stream always ends on a frame boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = RUN;
      RUN:       if (!enable) state_nxt = (frame_cnt_nxt == '0) ? IDLE : STOP_PEND;
      STOP_PEND: begin
        if (enable)                 state_nxt = RUN;
        else if (load && last_word) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Stage p1: output register, held while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tuser_p1 <= 1'b0;
      tlast_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= head[gnt_ch];
      tuser_p1 <= gnt_ch;
      tlast_p1 <= last_word;
    end else if (m_axis_tready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_p1;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tuser  = tuser_p1;
  assign m_axis_tlast  = tlast_p1;
  assign running       = (state != IDLE);

endmodule
